// File: rtl/edge_frame_sequencer.sv
// edge_frame_sequencer: frame-level sequencing for the gray->3x3 Sobel path.
// Tracks pixel coordinates, qualifies full 3x3 windows and latches the filter mode per frame.
`default_nettype none

module edge_frame_sequencer #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int WIN_LAT = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEnable,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [1:0]  iMode_req,
  output logic [1:0]  oMode,
  output logic [10:0] oCol,
  output logic [10:0] oRow,
  output logic        oWin_valid,
  output logic        oBorder,
  output logic        oFrame_done,
  output logic        oFrame_err,
  output logic        oBusy
);

  localparam int              CW        = $clog2(WIN_LAT + 1);
  localparam logic [10:0]     LAST_COL  = 11'(IMG_W - 1);
  localparam logic [10:0]     LAST_ROW  = 11'(IMG_H - 1);
  localparam logic [CW-1:0]   DRAIN_LEN = CW'(WIN_LAT);
  localparam logic [CW-1:0]   DRAIN_PRE = CW'(WIN_LAT - 1);
  localparam logic            LAT_ONE   = (WIN_LAT == 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t             state;
  logic               fval_q;
  logic [10:0]        col_cnt;
  logic [10:0]        row_cnt;
  logic [CW-1:0]      drain_cnt;
  logic [WIN_LAT-1:0] valid_pipe;
  logic [WIN_LAT-1:0] border_pipe;

  logic start_ok;
  logic at_last;
  logic accept;
  logic short_frame;
  logic win_ok;

  // col_cnt/row_cnt hold the position the next accepted pixel will take.
  always_comb begin
    start_ok    = iEnable & iFVAL & ~fval_q;
    at_last     = (col_cnt == LAST_COL) && (row_cnt == LAST_ROW);
    accept      = (state == ACTIVE) && iDVAL && (iFVAL || at_last);
    short_frame = (state == ACTIVE) && !iFVAL && !(iDVAL && at_last);
    win_ok      = (col_cnt >= 11'd2) && (row_cnt >= 11'd2);
  end

  assign oWin_valid = valid_pipe[WIN_LAT-1];
  assign oBorder    = border_pipe[WIN_LAT-1];

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state       <= IDLE;
      fval_q      <= 1'b0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      drain_cnt   <= '0;
      valid_pipe  <= '0;
      border_pipe <= '0;
      oMode       <= 2'd0;
      oCol        <= '0;
      oRow        <= '0;
      oFrame_done <= 1'b0;
      oFrame_err  <= 1'b0;
      oBusy       <= 1'b0;
    end else begin
      fval_q      <= iFVAL;
      oFrame_done <= 1'b0;
      oFrame_err  <= 1'b0;

      valid_pipe[0]  <= accept & win_ok;
      border_pipe[0] <= accept & ~win_ok;
      for (int i = 1; i < WIN_LAT; i++) begin
        valid_pipe[i]  <= valid_pipe[i-1];
        border_pipe[i] <= border_pipe[i-1];
      end

      if (accept) begin
        oCol <= col_cnt;
        oRow <= row_cnt;
        if (col_cnt == LAST_COL) begin
          col_cnt <= '0;
          row_cnt <= at_last ? 11'd0 : row_cnt + 11'd1;
        end else begin
          col_cnt <= col_cnt + 11'd1;
        end
      end

      case (state)
        IDLE: begin
          if (start_ok) begin
            oMode     <= iMode_req;
            col_cnt   <= '0;
            row_cnt   <= '0;
            oCol      <= '0;
            oRow      <= '0;
            drain_cnt <= '0;
            oBusy     <= 1'b1;
            state     <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (short_frame) begin
            oFrame_err  <= 1'b1;
            valid_pipe  <= '0;
            border_pipe <= '0;
            oBusy       <= 1'b0;
            state       <= IDLE;
          end else if (accept && at_last) begin
            drain_cnt   <= CW'(1);
            oFrame_done <= LAT_ONE;
            state       <= DRAIN;
          end
        end

        DRAIN: begin
          if (iDVAL) begin
            oFrame_err <= 1'b1;
          end
          // oFrame_done is visible during the final drain cycle, aligned with the last result.
          if (drain_cnt == DRAIN_LEN) begin
            if (start_ok) begin
              oMode     <= iMode_req;
              col_cnt   <= '0;
              row_cnt   <= '0;
              oCol      <= '0;
              oRow      <= '0;
              drain_cnt <= '0;
              state     <= ACTIVE;
            end else begin
              oBusy <= 1'b0;
              state <= IDLE;
            end
          end else begin
            drain_cnt   <= drain_cnt + CW'(1);
            oFrame_done <= (drain_cnt == DRAIN_PRE);
          end
        end

        default: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_edge_frame_sequencer.sv
// tb_edge_frame_sequencer: directed, table-driven checks of edge_frame_sequencer (4x3 frame, latency 2).
`default_nettype none

module tb_edge_frame_sequencer;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iEnable = 1'b0;
  logic        iFVAL = 1'b0;
  logic        iDVAL = 1'b0;
  logic [1:0]  iMode_req = 2'd0;
  logic [1:0]  oMode;
  logic [10:0] oCol;
  logic [10:0] oRow;
  logic        oWin_valid;
  logic        oBorder;
  logic        oFrame_done;
  logic        oFrame_err;
  logic        oBusy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done, n_err, n_wv, n_b;

  edge_frame_sequencer #(.IMG_W(4), .IMG_H(3), .WIN_LAT(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iEnable(iEnable), .iFVAL(iFVAL), .iDVAL(iDVAL),
    .iMode_req(iMode_req), .oMode(oMode), .oCol(oCol), .oRow(oRow),
    .oWin_valid(oWin_valid), .oBorder(oBorder), .oFrame_done(oFrame_done),
    .oFrame_err(oFrame_err), .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic       en, fv, dv;
    logic [1:0] md;
    logic [1:0] mode;
    logic [10:0] col, row;
    logic       wv, b, done, err, busy;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic en, fv, dv, input logic [1:0] md, mode,
                              input int col, row, input logic wv, b, done, err, busy);
    vec_t v;
    v.en = en; v.fv = fv; v.dv = dv; v.md = md; v.mode = mode;
    v.col = 11'(col); v.row = 11'(row);
    v.wv = wv; v.b = b; v.done = done; v.err = err; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_done = 0; n_err = 0; n_wv = 0; n_b = 0;
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic tick(input logic en, fv, dv, input logic [1:0] md);
    iEnable = en; iFVAL = fv; iDVAL = dv; iMode_req = md;
    @(posedge iCLK);
    #1;
    n_done += int'(oFrame_done);
    n_err  += int'(oFrame_err);
    n_wv   += int'(oWin_valid);
    n_b    += int'(oBorder);
  endtask

  function automatic logic [31:0] outs();
    return {3'b0, oMode, oCol, oRow, oWin_valid, oBorder, oFrame_done, oFrame_err, oBusy};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Case 1 table: continuous pixels, flags surface two cycles after acceptance.
    tbl[0]  = mk(1,1,0,0, 0, 0,0, 0,0,0,0,1);
    tbl[1]  = mk(1,1,1,0, 0, 0,0, 0,0,0,0,1);
    tbl[2]  = mk(1,1,1,0, 0, 1,0, 0,1,0,0,1);
    tbl[3]  = mk(1,1,1,0, 0, 2,0, 0,1,0,0,1);
    tbl[4]  = mk(1,1,1,0, 0, 3,0, 0,1,0,0,1);
    tbl[5]  = mk(1,1,1,0, 0, 0,1, 0,1,0,0,1);
    tbl[6]  = mk(1,1,1,0, 0, 1,1, 0,1,0,0,1);
    tbl[7]  = mk(1,1,1,0, 0, 2,1, 0,1,0,0,1);
    tbl[8]  = mk(1,1,1,0, 0, 3,1, 0,1,0,0,1);
    tbl[9]  = mk(1,1,1,0, 0, 0,2, 0,1,0,0,1);
    tbl[10] = mk(1,1,1,0, 0, 1,2, 0,1,0,0,1);
    tbl[11] = mk(1,1,1,0, 0, 2,2, 0,1,0,0,1);
    tbl[12] = mk(1,1,1,0, 0, 3,2, 1,0,0,0,1);
    tbl[13] = mk(1,0,0,0, 0, 3,2, 1,0,1,0,1);
    tbl[14] = mk(1,0,0,0, 0, 3,2, 0,0,0,0,0);

    #12;
    check("reset_outputs", outs(), 32'd0);
    @(posedge iCLK); #1;
    iRST = 1'b1;
    tick(0,0,0,0);
    check("idle_after_reset", outs(), 32'd0);

    clear_counts();
    for (int i = 0; i < 15; i++) begin
      vec_t v;
      v = tbl[i];
      tick(v.en, v.fv, v.dv, v.md);
      check($sformatf("vec%0d", i), outs(),
            {3'b0, v.mode, v.col, v.row, v.wv, v.b, v.done, v.err, v.busy});
    end
    check("c1_win_count", n_wv, 2);
    check("c1_border_count", n_b, 10);
    check("c1_done_count", n_done, 1);

    // Case 2: mode request changes mid-frame are ignored until the next start.
    tick(1,1,0,2);
    check("c2_mode_latched", oMode, 2);
    clear_counts();
    for (int p = 0; p < 12; p++) tick(1,1,1, (p < 6) ? 2'd2 : 2'd1);
    check("c2_mode_mid", oMode, 2);
    tick(1,0,0,1);
    check("c2_done_mode", {oFrame_done, oMode}, {1'b1, 2'd2});
    tick(1,0,0,1);
    check("c2_idle_mode", {oBusy, oMode}, {1'b0, 2'd2});
    tick(1,1,0,1);
    check("c2_next_mode", {oBusy, oMode}, {1'b1, 2'd1});

    // Case 3: frame valid drops after 7 pixels.
    clear_counts();
    for (int p = 0; p < 7; p++) tick(1,1,1,1);
    check("c3_coord7", {oCol, oRow}, {11'd2, 11'd1});
    tick(1,0,0,1);
    check("c3_err_cycle", {oFrame_err, oBusy, oBorder, oWin_valid}, 4'b1000);
    tick(1,0,0,1);
    check("c3_err_once", n_err, 1);
    check("c3_no_done", n_done, 0);

    // Enable low blocks a start even on an FVAL rise.
    tick(0,1,0,0);
    check("en_low_no_start", oBusy, 0);
    tick(0,0,0,0);

    // Case 4: 13 pixels, the extra one lands in DRAIN.
    tick(1,1,0,0);
    clear_counts();
    for (int p = 0; p < 13; p++) tick(1,1,1,0);
    check("c4_err_done", {oFrame_err, oFrame_done}, 2'b11);
    check("c4_coord_held", {oCol, oRow}, {11'd3, 11'd2});
    tick(1,0,0,0);
    check("c4_idle", oBusy, 0);
    check("c4_counts", {8'(n_done), 8'(n_err), 8'(n_wv), 8'(n_b)},
          {8'd1, 8'd1, 8'd2, 8'd10});

    // Case 5: asynchronous reset mid-frame.
    tick(1,1,0,3);
    for (int p = 0; p < 5; p++) tick(1,1,1,3);
    check("c5_pre_reset", {oMode, oCol, oRow}, {2'd3, 11'd0, 11'd1});
    #2 iRST = 1'b0;
    #1;
    check("c5_async_reset", outs(), 32'd0);
    iFVAL = 1'b0; iDVAL = 1'b0;
    @(posedge iCLK); #1;
    iRST = 1'b1;
    clear_counts();
    tick(1,0,0,0);
    tick(1,1,0,0);
    tick(1,1,1,0);
    check("c5_restart_p0", {oBusy, oCol, oRow}, {1'b1, 11'd0, 11'd0});
    tick(1,1,1,0);
    check("c5_restart_p1", {oCol, oRow}, {11'd1, 11'd0});
    check("c5_no_pulses", n_done + n_err, 0);
    tick(1,0,0,0);

    // Case 6: one pixel every three cycles, then back-to-back start on the done cycle.
    tick(1,0,0,0);
    tick(1,1,0,0);
    for (int p = 0; p < 12; p++) begin
      int  c, r;
      logic ev;
      c  = p % 4;
      r  = p / 4;
      ev = (c >= 2) && (r >= 2);
      tick(1,1,1,0);
      check($sformatf("c6_coord%0d", p), {oCol, oRow}, {11'(c), 11'(r)});
      if (p < 11) begin
        tick(1,1,0,0);
        check($sformatf("c6_flags%0d", p), {oWin_valid, oBorder}, {ev, ~ev});
        tick(1,1,0,0);
        check($sformatf("c6_gap%0d", p), {oWin_valid, oBorder, oFrame_done}, 3'b000);
      end else begin
        tick(1,0,0,0);
        check("c6_last_done", {oWin_valid, oBorder, oFrame_done, oBusy}, 4'b1011);
      end
    end
    tick(1,1,0,0);
    check("c6_back_to_back", {oBusy, oFrame_done, oCol, oRow}, {1'b1, 1'b0, 11'd0, 11'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
